clk_div_prog: RTL and testbench

//   Runtime-programmable clock divider / tick generator for the CPLD counter designs.
//   - Derives a divided square wave or a 1-cycle enable tick from clk_ht (100 kHz board clock).
//   - Divisor is reloadable through a load/ack handshake; a new value takes effect only on a

---
 rtl/clk_div_prog.sv | 89 ++++++++
 tb/tb_clk_div_prog.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider / tick generator: square wave or 1-cycle tick every div_cur cycles.
// Latency: outputs are registered and decode the counter value held in the same cycle.
// Backpressure: none; a divisor reload is held pending until a period boundary, then acked.
module clk_div_prog #(
  parameter int CNT_W       = 17,
  parameter int DEFAULT_DIV = 100000
) (
  input  logic             clk_ht,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic [CNT_W-1:0] div_cur,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_pend;
  logic             pend;
  logic             sq;

  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] p_next;
  logic             tick_next;
  logic             sq_next;
  logic [CNT_W-1:0] ld_val;

  // Next-state decode: counter advance, period switch at a boundary, and the output values
  // that the flops will show alongside the new counter value.
  always_comb begin
    wrap      = (cnt == div_cur - ONE);
    apply     = pend & (~en | wrap);
    ld_val    = (div_in < TWO) ? TWO : div_in;
    cnt_next  = cnt;
    p_next    = div_cur;
    tick_next = 1'b0;
    sq_next   = sq;
    if (!en) begin
      // Frozen: a pending divisor is taken immediately and the period restarts low.
      if (pend) begin
        cnt_next = '0;
        p_next   = div_pend;
        sq_next  = 1'b0;
      end
    end else begin
      cnt_next  = wrap ? '0 : cnt + ONE;
      p_next    = (wrap && pend) ? div_pend : div_cur;
      tick_next = (cnt_next == p_next - ONE);
      sq_next   = (cnt_next >= (p_next >> 1));
    end
  end

  // State and registered outputs; a load captured on the applying edge stays pending.
  always_ff @(posedge clk_ht) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_cur  <= DEF_DIV;
      div_pend <= DEF_DIV;
      pend     <= 1'b0;
      sq       <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      div_ack  <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      div_cur <= p_next;
      sq      <= sq_next;
      tick    <= tick_next;
      clk_out <= mode ? tick_next : sq_next;
      div_ack <= apply;
      if (div_load) begin
        div_pend <= ld_val;
        pend     <= 1'b1;
      end else if (apply) begin
        pend     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with DEFAULT_DIV=10, CNT_W=8.
// Expected values are hand-derived from the cycle position within each period.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_clk_div_prog;

  logic       clk_ht = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [7:0] div_in;
  logic       div_load;
  logic       div_ack;
  logic [7:0] div_cur;
  logic       clk_out;
  logic       tick;

  int n_cmp = 0;
  int n_err = 0;

  clk_div_prog #(.CNT_W(8), .DEFAULT_DIV(10)) dut (
    .clk_ht   (clk_ht),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .div_in   (div_in),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_cur  (div_cur),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_ht = ~clk_ht;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_ht);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    mode     = 1'b0;
    div_in   = 8'd3;
    div_load = 1'b1;

    // 1: reset with a load asserted throughout
    repeat (3) step();
    rst_n    = 1'b1;
    div_load = 1'b0;
    chk("rst_div_cur", div_cur, 10);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick",    tick,    0);
    chk("rst_ack",     div_ack, 0);

    // 2: free run, period 10 -> 5 low / 5 high, tick at cnt 9
    for (int i = 0; i < 20; i++) begin
      chk("run10_clk", clk_out, ((i % 10) >= 5) ? 1 : 0);
      chk("run10_tick", tick, ((i % 10) == 9) ? 1 : 0);
      step();
    end

    // 3: load 7 at cnt=3; current period of 10 completes
    repeat (3) step();
    div_in   = 8'd7;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    for (int c = 4; c < 10; c++) begin
      chk("old10_clk", clk_out, (c >= 5) ? 1 : 0);
      chk("old10_tick", tick, (c == 9) ? 1 : 0);
      chk("old10_ack", div_ack, 0);
      chk("old10_div", div_cur, 10);
      step();
    end
    chk("new7_div", div_cur, 7);
    for (int i = 0; i < 14; i++) begin
      chk("run7_clk", clk_out, ((i % 7) >= 3) ? 1 : 0);
      chk("run7_tick", tick, ((i % 7) == 6) ? 1 : 0);
      chk("run7_ack", div_ack, (i == 0) ? 1 : 0);
      step();
    end

    // 4: load 1 -> clamped to 2, then load 0 -> still 2
    div_in   = 8'd1;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    repeat (6) step();
    chk("clamp1_div", div_cur, 2);
    chk("clamp1_ack", div_ack, 1);
    for (int i = 0; i < 6; i++) begin
      chk("run2_clk", clk_out, i % 2);
      step();
    end
    div_in   = 8'd0;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    chk("clamp0_div", div_cur, 2);
    chk("clamp0_ack", div_ack, 1);

    // 5: back to 10, freeze at cnt=4, load 6 while frozen, resume
    div_in   = 8'd10;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    chk("re10_div", div_cur, 10);
    repeat (4) step();
    en = 1'b0;
    step();
    chk("frz_tick", tick, 0);
    chk("frz_clk",  clk_out, 0);
    div_in   = 8'd6;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk("frz_ld_ack", div_ack, 0);
    chk("frz_ld_div", div_cur, 10);
    step();
    chk("frz_ap_ack", div_ack, 1);
    chk("frz_ap_div", div_cur, 6);
    chk("frz_ap_clk", clk_out, 0);
    step();
    chk("frz_post_ack", div_ack, 0);
    chk("frz_post_tick", tick, 0);
    step();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("run6_clk", clk_out, ((i % 6) >= 3) ? 1 : 0);
      chk("run6_tick", tick, ((i % 6) == 5) ? 1 : 0);
      step();
    end

    // 6: tick mode; load 10, then 4 and 8 within a single period
    mode     = 1'b1;
    div_in   = 8'd10;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    for (int c = 1; c < 6; c++) begin
      chk("m1_p6_clk", clk_out, (c == 5) ? 1 : 0);
      step();
    end
    chk("m1_p10_div", div_cur, 10);
    for (int i = 0; i < 10; i++) begin
      chk("m1_p10_clk", clk_out, (i == 9) ? 1 : 0);
      chk("m1_p10_tick", tick, (i == 9) ? 1 : 0);
      chk("m1_p10_ack", div_ack, (i == 0) ? 1 : 0);
      if (i == 2 || i == 5) begin
        div_in   = (i == 2) ? 8'd4 : 8'd8;
        div_load = 1'b1;
      end
      step();
      div_load = 1'b0;
    end
    chk("last_win_div", div_cur, 8);
    for (int i = 0; i < 8; i++) begin
      chk("m1_p8_clk", clk_out, (i == 7) ? 1 : 0);
      chk("m1_p8_ack", div_ack, (i == 0) ? 1 : 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
